sdram_line_ctrl: RTL and testbench



---
 rtl/sdram_line_ctrl.sv | 155 +++++++++++++++
 tb/tb_sdram_line_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_line_ctrl.sv
// Line-transfer sequencer: optional dirty-line write-back, then optional line fill.
// It moves one byte per sdram strobe transaction and uses the cache array's byte port.
//
// state    | meaning
// IDLE     | waiting for a request, req_ready high
// WB_ISSUE | strobe held for a victim byte write
// WB_GAP   | strobe low, advance write-back byte
// RD_ISSUE | strobe held for a fill byte read
// RD_CAP   | strobe low, capture sdram byte into cache
// DONE     | one-cycle completion pulse
module sdram_line_ctrl #(
  parameter int DELAY_CYCLES = 2,
  parameter int OFFSET_BITS  = 3,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_wb,
  input  logic                   i_req_fill,
  input  logic [15:0]            i_wb_addr,
  input  logic [15:0]            i_fill_addr,
  output logic                   o_done,
  output logic                   o_busy,
  output logic [OFFSET_BITS-1:0] o_cache_off,
  output logic                   o_cache_we,
  output logic [DATA_WIDTH-1:0]  o_cache_wdata,
  input  logic [DATA_WIDTH-1:0]  i_cache_rdata,
  output logic [15:0]            o_sd_addr,
  output logic                   o_sd_wr_rd,
  output logic                   o_sd_mstrb,
  output logic [DATA_WIDTH-1:0]  o_sd_din,
  input  logic [DATA_WIDTH-1:0]  i_sd_dout
);

  localparam int WAIT_W = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(DELAY_CYCLES);
  localparam logic [OFFSET_BITS-1:0] BYTE_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_ISSUE, S_WB_GAP, S_RD_ISSUE, S_RD_CAP, S_DONE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [OFFSET_BITS-1:0] r_byte, w_byte_nxt;
  logic [WAIT_W-1:0]      r_wait, w_wait_nxt;
  logic [15-OFFSET_BITS:0] r_wb_line, r_fill_line;
  logic                   r_do_fill;
  logic                   w_accept;
  logic                   w_unused;

  // Low address bits select bytes within a line and are regenerated from r_byte.
  assign w_unused = ^{i_wb_addr[OFFSET_BITS-1:0], i_fill_addr[OFFSET_BITS-1:0]};
  assign w_accept = (r_state == S_IDLE) && i_req_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_byte      <= '0;
      r_wait      <= '0;
      r_wb_line   <= '0;
      r_fill_line <= '0;
      r_do_fill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_byte  <= w_byte_nxt;
      r_wait  <= w_wait_nxt;
      if (w_accept) begin
        r_wb_line   <= i_wb_addr[15:OFFSET_BITS];
        r_fill_line <= i_fill_addr[15:OFFSET_BITS];
        r_do_fill   <= i_req_fill;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_byte_nxt    = r_byte;
    w_wait_nxt    = r_wait;
    o_req_ready   = 1'b0;
    o_done        = 1'b0;
    o_busy        = 1'b1;
    o_cache_off   = '0;
    o_cache_we    = 1'b0;
    o_cache_wdata = '0;
    o_sd_addr     = '0;
    o_sd_wr_rd    = 1'b0;
    o_sd_mstrb    = 1'b0;
    o_sd_din      = '0;
    case (r_state)
      S_IDLE: begin
        o_busy      = 1'b0;
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (i_req_wb)        w_state_nxt = S_WB_ISSUE;
          else if (i_req_fill) w_state_nxt = S_RD_ISSUE;
          else                 w_state_nxt = S_DONE;
        end
      end
      S_WB_ISSUE: begin
        o_sd_mstrb  = 1'b1;
        o_sd_wr_rd  = 1'b1;
        o_sd_addr   = {r_wb_line, r_byte};
        o_cache_off = r_byte;
        o_sd_din    = i_cache_rdata;
        if (r_wait == WAIT_LAST) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_WB_GAP;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_WB_GAP: begin
        o_sd_addr = {r_wb_line, r_byte};
        if (r_byte == BYTE_LAST) begin
          w_byte_nxt  = '0;
          w_state_nxt = r_do_fill ? S_RD_ISSUE : S_DONE;
        end else begin
          w_byte_nxt  = r_byte + 1'b1;
          w_state_nxt = S_WB_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        o_sd_mstrb = 1'b1;
        o_sd_addr  = {r_fill_line, r_byte};
        if (r_wait == WAIT_LAST) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_RD_CAP;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_RD_CAP: begin
        o_sd_addr     = {r_fill_line, r_byte};
        o_cache_we    = 1'b1;
        o_cache_off   = r_byte;
        o_cache_wdata = i_sd_dout;
        if (r_byte == BYTE_LAST) begin
          w_byte_nxt  = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_byte_nxt  = r_byte + 1'b1;
          w_state_nxt = S_RD_ISSUE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sdram_line_ctrl.sv
// Bench for sdram_line_ctrl: behavioural sdram and cache-line models, vector table
// of line requests, plus hand-written reset and idle sequences.
module tb_sdram_line_ctrl;
  localparam int DELAY = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
  logic [15:0] wb_addr = '0, fill_addr = '0;
  logic        req_ready, done, busy, cache_we, sd_wr_rd, sd_mstrb;
  logic [2:0]  cache_off;
  logic [7:0]  cache_wdata, cache_rdata, sd_din, sd_dout;
  logic [15:0] sd_addr;

  logic [7:0]  sd_mem [0:65535];
  logic [7:0]  cache_mem [0:7];
  int          sd_cnt;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, run = 0, strb_cnt = 0, we_cnt = 0, last_wr = 0, first_rd = 0;
  logic [7:0] mon_base = '0;
  bit in_rst_seq = 1'b0;

  sdram_line_ctrl #(.DELAY_CYCLES(DELAY), .OFFSET_BITS(3), .DATA_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wb(req_wb), .i_req_fill(req_fill), .i_wb_addr(wb_addr),
    .i_fill_addr(fill_addr), .o_done(done), .o_busy(busy),
    .o_cache_off(cache_off), .o_cache_we(cache_we), .o_cache_wdata(cache_wdata),
    .i_cache_rdata(cache_rdata), .o_sd_addr(sd_addr), .o_sd_wr_rd(sd_wr_rd),
    .o_sd_mstrb(sd_mstrb), .o_sd_din(sd_din), .i_sd_dout(sd_dout)
  );

  always #5 clk = ~clk;

  // sdram: op happens on the edge that ends the (DELAY+1)th strobe cycle
  always @(posedge clk) begin
    if (rst) begin
      sd_cnt  <= 0;
      sd_dout <= '0;
    end else if (sd_mstrb) begin
      if (sd_cnt == DELAY) begin
        sd_cnt <= 0;
        if (sd_wr_rd) sd_mem[sd_addr] <= sd_din;
        else          sd_dout <= sd_mem[sd_addr];
      end else begin
        sd_cnt <= sd_cnt + 1;
      end
    end
  end

  assign cache_rdata = cache_mem[cache_off];
  always @(posedge clk) if (cache_we) cache_mem[cache_off] <= cache_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst || in_rst_seq) begin
      run = 0;
    end else begin
      if (sd_mstrb) begin
        strb_cnt++;
        run++;
        if (sd_wr_rd) last_wr = cyc;
        else if (first_rd == 0) first_rd = cyc;
      end else if (run != 0) begin
        chk("strobe_run_len", run, DELAY + 1);
        run = 0;
      end
      if (cache_we) begin
        chk("we_offset", cache_off, we_cnt);
        chk("we_data", cache_wdata, 8'(mon_base + we_cnt));
        we_cnt++;
      end
    end
  end

  typedef struct {
    bit         wb;
    bit         fill;
    logic [15:0] wba;
    logic [15:0] fla;
    logic [7:0] base;
    bit         hold;
    int         lat;
    int         strb;
    int         we;
  } vec_t;

  function automatic logic [63:0] line_of(input logic [7:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(b + i);
    return r;
  endfunction

  task automatic run_req(input vec_t v);
    int k, acc;
    bit got;
    logic [63:0] line;
    @(negedge clk);
    if (v.wb) for (int i = 0; i < 8; i++) sd_mem[{v.wba[15:3], 3'(i)}] <= 8'hEE;
    req_wb = v.wb; req_fill = v.fill; wb_addr = v.wba; fill_addr = v.fla;
    req_valid = 1'b1; mon_base = v.base;
    chk("ready_before_req", req_ready, 1);
    @(posedge clk);
    strb_cnt = 0; we_cnt = 0; last_wr = 0; first_rd = 0;
    got = 0; acc = 0; k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (!v.hold) req_valid = 1'b0;
      if (req_valid && req_ready) acc++;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("latency", k, v.lat);
    chk("ready_in_done", req_ready, 0);
    chk("busy_in_done", busy, 1);
    if (v.hold) chk("reaccept_while_busy", acc, 0);
    @(negedge clk);
    chk("ready_after_done", req_ready, 1);
    req_valid = 1'b0;
    chk("strobe_cycles", strb_cnt, v.strb);
    chk("cache_we_pulses", we_cnt, v.we);
    if (v.wb) begin
      for (int i = 0; i < 8; i++) line[i*8 +: 8] = sd_mem[{v.wba[15:3], 3'(i)}];
      chk("wb_line_in_sdram", line, line_of(8'h10));
    end
    if (v.fill) begin
      for (int i = 0; i < 8; i++) line[i*8 +: 8] = cache_mem[i];
      chk("fill_line_in_cache", line, line_of(v.base));
    end
    if (v.wb && v.fill) chk("wb_before_first_read", (last_wr < first_rd), 1);
    if (!v.wb && !v.fill) chk("noop_no_strobe", strb_cnt, 0);
  endtask

  vec_t vecs [5];

  initial begin
    int bad, k, dcnt;
    vec_t vr;
    vecs[0] = '{wb:0, fill:1, wba:16'h0000, fla:16'h1235, base:8'hA0, hold:0, lat:33, strb:24, we:8};
    vecs[1] = '{wb:1, fill:0, wba:16'h0040, fla:16'h0000, base:8'h00, hold:0, lat:33, strb:24, we:0};
    vecs[2] = '{wb:1, fill:1, wba:16'h0040, fla:16'h0080, base:8'hC0, hold:1, lat:65, strb:48, we:8};
    vecs[3] = '{wb:0, fill:0, wba:16'h0123, fla:16'h0456, base:8'h00, hold:0, lat:1, strb:0, we:0};
    vecs[4] = '{wb:1, fill:1, wba:16'h2008, fla:16'h0FFC, base:8'h50, hold:0, lat:65, strb:48, we:8};

    for (int i = 0; i < 8; i++) begin
      sd_mem[16'h1230 + i] <= 8'(8'hA0 + i);
      sd_mem[16'h0080 + i] <= 8'(8'hC0 + i);
      sd_mem[16'h0FF8 + i] <= 8'(8'h50 + i);
      cache_mem[i] <= 8'h00;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mstrb", sd_mstrb, 0);
    chk("rst_cache_we", cache_we, 0);
    chk("rst_sd_addr", sd_addr, 0);
    chk("rst_wr_rd", sd_wr_rd, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (sd_mstrb || done || busy || !req_ready) bad++;
    end
    chk("idle_quiet_cycles", bad, 0);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) cache_mem[i] <= 8'(8'h10 + i);
      run_req(vecs[v]);
    end

    // reset in the middle of fill byte 3
    @(negedge clk);
    for (int i = 0; i < 8; i++) cache_mem[i] <= 8'h00;
    req_wb = 0; req_fill = 1; fill_addr = 16'h1235; req_valid = 1; mon_base = 8'hA0;
    @(posedge clk);
    we_cnt = 0;
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!(sd_mstrb && !sd_wr_rd && sd_addr[2:0] == 3'd3) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reached_byte3", (k < 100), 1);
    in_rst_seq = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_mstrb", sd_mstrb, 0);
    chk("midrst_cache_we", cache_we, 0);
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || sd_mstrb) dcnt++;
    end
    chk("midrst_no_done_no_strobe", dcnt, 0);
    in_rst_seq = 1'b0;
    vr = '{wb:0, fill:1, wba:16'h0000, fla:16'h0085, base:8'hC0, hold:0, lat:33, strb:24, we:8};
    run_req(vr);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
